// File: rtl/ace_read_arbiter.sv
// Two-port round-robin read arbiter onto a single coherent-bus read master.
// One burst outstanding at a time; the AR channel is registered and R beats return to the owner.
module ace_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,

  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,

  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,

  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic last_grant;
  logic owner;
  logic req;
  logic winner;
  logic accept;
  logic last_beat;

  // Winner: a lone requester wins; on a tie the port that did not go last wins.
  always_comb begin
    req    = s0_arvalid | s1_arvalid;
    winner = 1'b0;
    if (s0_arvalid && s1_arvalid) begin
      winner = ~last_grant;
    end else begin
      winner = s1_arvalid;
    end
  end

  assign accept    = (state == IDLE) && req;
  assign last_beat = (state == DATA) && m_rvalid && m_rready && m_rlast;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req)       state_nxt = ADDR;
      ADDR:    if (m_arready) state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // owner doubles as the visible grant: it holds the last owner once back in IDLE,
  // while last_grant starts at 1 so that s0 wins the first tie yet grant reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      m_araddr   <= '0;
      m_arlen    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner    <= winner;
        m_araddr <= winner ? s1_araddr : s0_araddr;
        m_arlen  <= winner ? s1_arlen  : s0_arlen;
      end
      if (last_beat) begin
        last_grant <= owner;
      end
    end
  end

  always_comb begin
    s0_arready = accept && !winner;
    s1_arready = accept &&  winner;
    m_arvalid  = (state == ADDR);
    busy       = (state != IDLE);
    grant      = owner;

    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    if (state == DATA) begin
      m_rready  = owner ? s1_rready : s0_rready;
      s0_rvalid = !owner && m_rvalid;
      s1_rvalid =  owner && m_rvalid;
    end

    s0_rdata = m_rdata;
    s0_rresp = m_rresp;
    s0_rlast = m_rlast;
    s1_rdata = m_rdata;
    s1_rresp = m_rresp;
    s1_rlast = m_rlast;
  end

endmodule

// File: tb/tb_ace_read_arbiter.sv
// Directed bench for ace_read_arbiter: grant order, AR stalls, R back-pressure, reset abort.
module tb_ace_read_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]  s0_arlen, s1_arlen, m_arlen;
  logic        s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic [31:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp;
  logic        s0_rlast, s1_rlast, m_rlast;
  logic        s0_rvalid, s1_rvalid, m_rvalid;
  logic        s0_rready, s1_rready, m_rready;
  logic        m_arvalid, m_arready;
  logic        busy, grant;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ace_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Arbitration cycle with both requests visible, expected winner exp_port,
  // single-beat burst (arlen=0) delivering data d; ends in IDLE after the last beat.
  task automatic single_burst(input logic exp_port, input logic [31:0] d, input string tag);
    m_arready = 1'b1;
    settle();
    chk({tag, "_s0_arready"}, 32'(s0_arready), 32'(!exp_port));
    chk({tag, "_s1_arready"}, 32'(s1_arready), 32'(exp_port));
    step();
    if (exp_port) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    settle();
    chk({tag, "_m_arvalid"}, 32'(m_arvalid), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_port));
    step();
    m_rvalid = 1'b1; m_rdata = d; m_rlast = 1'b1; m_rresp = 2'b00;
    s0_rready = 1'b1; s1_rready = 1'b1;
    settle();
    chk({tag, "_owner_rvalid"}, 32'(exp_port ? s1_rvalid : s0_rvalid), 32'd1);
    chk({tag, "_other_rvalid"}, 32'(exp_port ? s0_rvalid : s1_rvalid), 32'd0);
    chk({tag, "_no_ar_in_data"}, 32'(s0_arready | s1_arready), 32'd0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
    s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    // Reset values
    #12;
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_araddr", m_araddr, 32'd0);
    chk("rst_m_arlen", 32'(m_arlen), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Single s0 read of 4 beats
    s0_arvalid = 1'b1; s0_araddr = 32'h0000_1000; s0_arlen = 8'd3; m_arready = 1'b1;
    settle();
    chk("t1_s0_arready", 32'(s0_arready), 32'd1);
    chk("t1_s1_arready", 32'(s1_arready), 32'd0);
    chk("t1_m_arvalid_pre", 32'(m_arvalid), 32'd0);
    step();
    s0_arvalid = 1'b0;
    settle();
    chk("t1_s0_arready_drop", 32'(s0_arready), 32'd0);
    chk("t1_m_arvalid", 32'(m_arvalid), 32'd1);
    chk("t1_m_araddr", m_araddr, 32'h0000_1000);
    chk("t1_m_arlen", 32'(m_arlen), 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    settle();
    chk("t1_m_arvalid_off", 32'(m_arvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA0 + 32'(i); m_rlast = (i == 3); s0_rready = 1'b1;
      settle();
      chk("t1_s0_rvalid", 32'(s0_rvalid), 32'd1);
      chk("t1_s1_rvalid", 32'(s1_rvalid), 32'd0);
      chk("t1_s0_rdata", s0_rdata, 32'hA0 + 32'(i));
      chk("t1_s0_rlast", 32'(s0_rlast), 32'(i == 3));
      chk("t1_m_rready", 32'(m_rready), 32'd1);
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_grant_idle", 32'(grant), 32'd0);

    // Alternating grants from reset: s0, s1, s0
    rst = 1'b0;
    step();
    rst = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 32'h2000; s0_arlen = 8'd0;
    s1_arvalid = 1'b1; s1_araddr = 32'h3000; s1_arlen = 8'd0;
    single_burst(1'b0, 32'hC0, "t2a");
    s0_arvalid = 1'b1;
    single_burst(1'b1, 32'hC1, "t2b");
    s1_arvalid = 1'b1;
    single_burst(1'b0, 32'hC2, "t2c");

    // AR stall: s1 granted, m_arready low 5 cycles, s0 also requesting
    s0_arvalid = 1'b0; s1_arvalid = 1'b1; s1_araddr = 32'h4000; s1_arlen = 8'd1;
    m_arready = 1'b0;
    settle();
    chk("t3_s1_arready", 32'(s1_arready), 32'd1);
    step();
    s0_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_m_arvalid", 32'(m_arvalid), 32'd1);
      chk("t3_m_araddr", m_araddr, 32'h4000);
      chk("t3_no_arready", 32'(s0_arready | s1_arready), 32'd0);
      step();
    end
    m_arready = 1'b1; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    step();

    // s1 burst with s1_rready held low for 3 cycles on the first beat
    m_rvalid = 1'b1; m_rdata = 32'hB0; m_rlast = 1'b0; m_rresp = 2'b10;
    s1_rready = 1'b0; s0_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_m_rready_low", 32'(m_rready), 32'd0);
      chk("t4_s1_rvalid", 32'(s1_rvalid), 32'd1);
      chk("t4_s0_rvalid", 32'(s0_rvalid), 32'd0);
      step();
    end
    s1_rready = 1'b1;
    settle();
    chk("t4_m_rready", 32'(m_rready), 32'd1);
    chk("t4_rdata_b0", s1_rdata, 32'hB0);
    chk("t4_rresp", 32'(s1_rresp), 32'd2);
    step();
    m_rdata = 32'hB1; m_rlast = 1'b1; m_rresp = 2'b00;
    settle();
    chk("t4_rdata_b1", s1_rdata, 32'hB1);
    chk("t4_s0_rvalid_last", 32'(s0_rvalid), 32'd0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("t4_busy_done", 32'(busy), 32'd0);
    chk("t4_grant_idle", 32'(grant), 32'd1);

    // s0 alone, three back-to-back single-beat bursts
    for (int i = 0; i < 3; i++) begin
      s0_arvalid = 1'b1; s0_araddr = 32'h5000 + 32'(i * 4); s0_arlen = 8'd0;
      single_burst(1'b0, 32'hD0 + 32'(i), "t5");
    end

    // Asynchronous reset in the middle of an 8-beat burst
    s0_arvalid = 1'b1; s0_araddr = 32'h6000; s0_arlen = 8'd7; m_arready = 1'b1;
    step();
    s0_arvalid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hE0 + 32'(i); m_rlast = 1'b0; s0_rready = 1'b1;
      settle();
      chk("t6_s0_rvalid", 32'(s0_rvalid), 32'd1);
      step();
    end
    m_rdata = 32'hE2;
    settle();
    rst = 1'b0;
    settle();
    chk("t6_rst_s0_rvalid", 32'(s0_rvalid), 32'd0);
    chk("t6_rst_m_rready", 32'(m_rready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("t6_rst_m_araddr", m_araddr, 32'd0);
    chk("t6_rst_m_arlen", 32'(m_arlen), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    step();
    rst = 1'b1; m_rvalid = 1'b0;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    settle();
    chk("t6_post_s0_arready", 32'(s0_arready), 32'd1);
    chk("t6_post_s1_arready", 32'(s1_arready), 32'd0);
    step();
    settle();
    chk("t6_post_grant", 32'(grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
